dfs_drp_ctrl: RTL and testbench



---
 rtl/dfs_drp_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_dfs_drp_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dfs_drp_ctrl.sv
// DFS actuator: converts a requested frequency into an MMCM CLKOUT divider and
// programs it over DRP, holding the MMCM in reset until both registers are written.
module dfs_drp_ctrl #(
  parameter int         DATA_WIDTH   = 13,
  parameter int         VCO_FREQ     = 6400,
  parameter logic [6:0] INIT_DIV     = 7'd8,
  parameter logic [6:0] REG1_ADDR    = 7'h08,
  parameter logic [6:0] REG2_ADDR    = 7'h09,
  parameter int         DRDY_TIMEOUT = 255,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOCK_MASK    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_en_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [6:0]            cur_div_o,
  output logic [6:0]            drp_addr_o,
  output logic [15:0]           drp_di_o,
  output logic                  drp_den_o,
  output logic                  drp_dwe_o,
  input  logic                  drp_drdy_i,
  output logic                  mmcm_rst_o,
  input  logic                  mmcm_locked_i
);

  localparam int                CNT_W       = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [15:0]       DRDY_LAST   = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0]       LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]       LOCK_MASK_C = 16'(LOCK_MASK);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_WR1, S_WAIT1, S_WR2, S_WAIT2, S_WAIT_LOCK, S_ACK
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_div_done;
  logic                  w_wr2_done;
  logic                  w_timeout;

  logic [DATA_WIDTH-1:0] r_req;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [15:0]           r_wait_cnt;
  logic [6:0]            r_div;
  logic [1:0]            r_reg2_bits;

  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_q_nxt;
  logic [6:0]            w_div;
  logic [5:0]            w_high;
  logic [5:0]            w_low;
  logic                  w_edge;
  logic                  w_nocnt;

  logic                  r_ack;
  logic                  r_busy;
  logic                  r_err;
  logic [6:0]            r_cur_div;
  logic [6:0]            r_drp_addr;
  logic [15:0]           r_drp_di;
  logic                  r_drp_den;
  logic                  r_mmcm_rst;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_div_done = 1'b0;
    w_wr2_done = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_en_i) begin
          w_accept = 1'b1;
          w_next   = S_DIV;
        end
      end
      S_DIV: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_div_done = 1'b1;
          w_next     = S_WR1;
        end
      end
      S_WR1: w_next = S_WAIT1;
      S_WAIT1: begin
        if (drp_drdy_i) begin
          w_next = S_WR2;
        end else if (r_wait_cnt == DRDY_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_WR2: w_next = S_WAIT2;
      S_WAIT2: begin
        if (drp_drdy_i) begin
          w_wr2_done = 1'b1;
          w_next     = S_WAIT_LOCK;
        end else if (r_wait_cnt == DRDY_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_WAIT_LOCK: begin
        if (mmcm_locked_i && (r_wait_cnt >= LOCK_MASK_C)) begin
          w_next = S_ACK;
        end else if (r_wait_cnt == LOCK_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One restoring-division step; the quotient bits shift into r_dvd as the dividend shifts out.
  always_comb begin
    w_trial   = {r_rem, r_dvd[DATA_WIDTH-1]};
    w_ge      = (w_trial >= {1'b0, r_req});
    w_rem_nxt = w_trial[DATA_WIDTH-1:0] - (w_ge ? r_req : '0);
    w_q_nxt   = {r_dvd[DATA_WIDTH-2:0], w_ge};

    if ((r_req == '0) || (w_q_nxt > DATA_WIDTH'(126))) w_div = 7'd126;
    else if (w_q_nxt == '0)                             w_div = 7'd1;
    else                                                w_div = w_q_nxt[6:0];

    w_high  = w_div[6:1];
    w_low   = w_div[5:0] - w_high;
    w_edge  = w_div[0];
    w_nocnt = 1'b0;
    // Divide-by-1 bypasses the counter entirely, so the edge bit has no meaning there.
    if (w_div == 7'd1) begin
      w_high  = 6'd1;
      w_low   = 6'd1;
      w_edge  = 1'b0;
      w_nocnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cur_div   <= INIT_DIV;
      r_drp_addr  <= '0;
      r_drp_di    <= '0;
      r_drp_den   <= 1'b0;
      r_mmcm_rst  <= 1'b0;
      r_req       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_div       <= INIT_DIV;
      r_reg2_bits <= '0;
    end else begin
      r_ack     <= (w_next == S_ACK);
      r_busy    <= (w_next != S_IDLE);
      r_drp_den <= (w_next == S_WR1) || (w_next == S_WR2);

      if (w_next != r_state) r_wait_cnt <= '0;
      else                   r_wait_cnt <= r_wait_cnt + 16'd1;

      if (w_accept) begin
        r_req      <= req_data_i;
        r_err      <= 1'b0;
        r_mmcm_rst <= 1'b1;
        r_rem      <= '0;
        r_dvd      <= DATA_WIDTH'(VCO_FREQ);
        r_bit_cnt  <= '0;
      end

      if (r_state == S_DIV) begin
        r_rem     <= w_rem_nxt;
        r_dvd     <= w_q_nxt;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end

      if (w_div_done) begin
        r_div       <= w_div;
        r_reg2_bits <= {w_edge, w_nocnt};
        r_drp_addr  <= REG1_ADDR;
        r_drp_di    <= {4'b0, w_high, w_low};
      end

      if ((r_state == S_WAIT1) && (w_next == S_WR2)) begin
        r_drp_addr <= REG2_ADDR;
        r_drp_di   <= {8'b0, r_reg2_bits, 6'b0};
      end

      if (w_wr2_done) begin
        r_cur_div  <= r_div;
        r_mmcm_rst <= 1'b0;
      end

      if (w_timeout) begin
        r_err      <= 1'b1;
        r_mmcm_rst <= 1'b0;
      end
    end
  end

  assign ack_o      = r_ack;
  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign cur_div_o  = r_cur_div;
  assign drp_addr_o = r_drp_addr;
  assign drp_di_o   = r_drp_di;
  assign drp_den_o  = r_drp_den;
  assign drp_dwe_o  = r_drp_den;
  assign mmcm_rst_o = r_mmcm_rst;

endmodule

// File: tb/tb_dfs_drp_ctrl.sv
// Self-checking bench for dfs_drp_ctrl: a table of requests with hand-computed
// divider/DRP values, plus directed sequences for timeouts, masking and reset.
module tb_dfs_drp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_en_i = 1'b0;
  logic [12:0] req_data_i = '0;
  logic        ack_o, busy_o, err_o;
  logic [6:0]  cur_div_o, drp_addr_o;
  logic [15:0] drp_di_o;
  logic        drp_den_o, drp_dwe_o;
  logic        drp_drdy_i = 1'b0;
  logic        mmcm_rst_o;
  logic        mmcm_locked_i = 1'b0;

  dfs_drp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_en_i(req_en_i), .req_data_i(req_data_i),
    .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o), .cur_div_o(cur_div_o),
    .drp_addr_o(drp_addr_o), .drp_di_o(drp_di_o), .drp_den_o(drp_den_o),
    .drp_dwe_o(drp_dwe_o), .drp_drdy_i(drp_drdy_i), .mmcm_rst_o(mmcm_rst_o),
    .mmcm_locked_i(mmcm_locked_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] req;
    logic [6:0]  div;
    logic [15:0] reg1;
    logic [15:0] reg2;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int failures = 0;

  int          cycle;
  int          wrCount;
  logic [6:0]  wrAddr[8];
  logic [15:0] wrData[8];
  int          denCycle[8];
  int          ackCount;
  int          ackCycle;
  int          rstFallCycle;
  int          dweErrors = 0;
  logic        prevDen = 1'b0;
  logic        prevRst = 1'b0;
  logic        autoDrdy = 1'b1;
  int          lockMode = 1;

  logic        busyAtStart, rstAtStart, errAtStart;
  logic        errAtAck, rstAtAck, busyAfterAck;
  logic [6:0]  divAtAck;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock, observe the post-edge outputs, then drive the DRP/lock responders.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
    if (drp_den_o) begin
      if (wrCount < 8) begin
        wrAddr[wrCount]   = drp_addr_o;
        wrData[wrCount]   = drp_di_o;
        denCycle[wrCount] = cycle;
      end
      wrCount++;
    end
    if (drp_dwe_o !== drp_den_o) dweErrors++;
    if (ack_o) begin
      ackCount++;
      ackCycle = cycle;
    end
    if (prevRst && !mmcm_rst_o) rstFallCycle = cycle;
    prevRst       = mmcm_rst_o;
    drp_drdy_i    = autoDrdy && prevDen;
    prevDen       = drp_den_o;
    mmcm_locked_i = (lockMode == 2) || ((lockMode == 1) && !mmcm_rst_o);
  endtask

  task automatic clearTracking();
    cycle        = 0;
    wrCount      = 0;
    ackCount     = 0;
    ackCycle     = -1;
    rstFallCycle = -1;
  endtask

  task automatic applyStimulus(input logic [12:0] req);
    clearTracking();
    req_data_i = req;
    req_en_i   = 1'b1;
    stepCycle();
    req_en_i   = 1'b0;
    busyAtStart = busy_o;
    rstAtStart  = mmcm_rst_o;
    errAtStart  = err_o;
  endtask

  task automatic runRequest(input logic [12:0] req, input int budget);
    applyStimulus(req);
    while (ackCount == 0 && cycle < budget) stepCycle();
    if (ackCount == 0) checkOutput("ack_within_budget", 32'd0, 32'd1);
    errAtAck = err_o;
    rstAtAck = mmcm_rst_o;
    divAtAck = cur_div_o;
    stepCycle();
    busyAfterAck = busy_o;
    stepCycle();
    stepCycle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ack"},      {31'd0, ack_o},      32'd0);
    checkOutput({tag, "_busy"},     {31'd0, busy_o},     32'd0);
    checkOutput({tag, "_err"},      {31'd0, err_o},      32'd0);
    checkOutput({tag, "_den"},      {31'd0, drp_den_o},  32'd0);
    checkOutput({tag, "_dwe"},      {31'd0, drp_dwe_o},  32'd0);
    checkOutput({tag, "_mmcm_rst"}, {31'd0, mmcm_rst_o}, 32'd0);
    checkOutput({tag, "_addr"},     {25'd0, drp_addr_o}, 32'd0);
    checkOutput({tag, "_di"},       {16'd0, drp_di_o},   32'd0);
    checkOutput({tag, "_cur_div"},  {25'd0, cur_div_o},  32'd8);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{req: 13'd480,  div: 7'd13,  reg1: 16'h0187, reg2: 16'h0080};
    vecs[1] = '{req: 13'd6400, div: 7'd1,   reg1: 16'h0041, reg2: 16'h0040};
    vecs[2] = '{req: 13'd40,   div: 7'd126, reg1: 16'h0FFF, reg2: 16'h0000};
    vecs[3] = '{req: 13'd0,    div: 7'd126, reg1: 16'h0FFF, reg2: 16'h0000};
    vecs[4] = '{req: 13'd1000, div: 7'd6,   reg1: 16'h00C3, reg2: 16'h0000};
    vecs[5] = '{req: 13'd3200, div: 7'd2,   reg1: 16'h0041, reg2: 16'h0000};
    vecs[6] = '{req: 13'd51,   div: 7'd125, reg1: 16'h0FBF, reg2: 16'h0080};
    vecs[7] = '{req: 13'd8191, div: 7'd1,   reg1: 16'h0041, reg2: 16'h0040};
    vecs[8] = '{req: 13'd2133, div: 7'd3,   reg1: 16'h0042, reg2: 16'h0080};

    clearTracking();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    checkResetValues("reset");
    rst_n = 1'b1;
    stepCycle();

    for (int i = 0; i < 9; i++) begin
      autoDrdy = 1'b1;
      lockMode = 1;
      runRequest(vecs[i].req, 200);
      checkOutput($sformatf("v%0d_busy_start", i), {31'd0, busyAtStart}, 32'd1);
      checkOutput($sformatf("v%0d_rst_start", i),  {31'd0, rstAtStart},  32'd1);
      checkOutput($sformatf("v%0d_wr_count", i),   wrCount,              32'd2);
      checkOutput($sformatf("v%0d_reg1_addr", i),  {25'd0, wrAddr[0]},   32'h08);
      checkOutput($sformatf("v%0d_reg1_data", i),  {16'd0, wrData[0]},   {16'd0, vecs[i].reg1});
      checkOutput($sformatf("v%0d_reg2_addr", i),  {25'd0, wrAddr[1]},   32'h09);
      checkOutput($sformatf("v%0d_reg2_data", i),  {16'd0, wrData[1]},   {16'd0, vecs[i].reg2});
      checkOutput($sformatf("v%0d_den1_cycle", i), denCycle[0],          32'd14);
      checkOutput($sformatf("v%0d_den2_cycle", i), denCycle[1],          32'd16);
      checkOutput($sformatf("v%0d_rst_fall", i),   rstFallCycle,         32'd18);
      checkOutput($sformatf("v%0d_ack_cycle", i),  ackCycle,             32'd23);
      checkOutput($sformatf("v%0d_ack_count", i),  ackCount,             32'd1);
      checkOutput($sformatf("v%0d_cur_div", i),    {25'd0, divAtAck},    {25'd0, vecs[i].div});
      checkOutput($sformatf("v%0d_err", i),        {31'd0, errAtAck},    32'd0);
      checkOutput($sformatf("v%0d_busy_after", i), {31'd0, busyAfterAck}, 32'd0);
    end
    checkOutput("dwe_equals_den", dweErrors, 32'd0);

    // DRDY never arrives: 255 cycles in S_WAIT1 then an error ack, divider unchanged.
    autoDrdy = 1'b0;
    runRequest(13'd1000, 400);
    checkOutput("drdy_to_ack_cycle", ackCycle,           32'd270);
    checkOutput("drdy_to_wr_count",  wrCount,            32'd1);
    checkOutput("drdy_to_err",       {31'd0, errAtAck},  32'd1);
    checkOutput("drdy_to_mmcm_rst",  {31'd0, rstAtAck},  32'd0);
    checkOutput("drdy_to_cur_div",   {25'd0, divAtAck},  32'd3);
    checkOutput("drdy_to_ack_count", ackCount,           32'd1);

    autoDrdy = 1'b1;
    runRequest(13'd480, 200);
    checkOutput("err_clear_on_accept", {31'd0, errAtStart}, 32'd0);
    checkOutput("after_err_cur_div",   {25'd0, divAtAck},   32'd13);
    checkOutput("after_err_err",       {31'd0, errAtAck},   32'd0);

    // Lock held high throughout: the mask still delays the ack.
    lockMode = 2;
    runRequest(13'd1000, 200);
    checkOutput("lock_high_mask_gap", ackCycle - rstFallCycle, 32'd5);
    checkOutput("lock_high_ack_cycle", ackCycle,               32'd23);

    // Lock never rises: lock timeout after the divider was written.
    lockMode = 0;
    runRequest(13'd3200, 70000);
    checkOutput("lock_to_ack_cycle", ackCycle,          32'd65553);
    checkOutput("lock_to_err",       {31'd0, errAtAck}, 32'd1);
    checkOutput("lock_to_cur_div",   {25'd0, divAtAck}, 32'd2);
    checkOutput("lock_to_mmcm_rst",  {31'd0, rstAtAck}, 32'd0);

    // Requests while busy are ignored.
    lockMode = 1;
    applyStimulus(13'd480);
    while (ackCount == 0 && cycle < 200) begin
      if (cycle == 4 || cycle == 15 || cycle == 20) begin
        req_en_i   = 1'b1;
        req_data_i = 13'd40;
      end else begin
        req_en_i = 1'b0;
      end
      stepCycle();
    end
    req_en_i = 1'b0;
    for (int k = 0; k < 4; k++) stepCycle();
    checkOutput("busy_ign_err_clear", {31'd0, errAtStart}, 32'd0);
    checkOutput("busy_ign_wr_count",  wrCount,             32'd2);
    checkOutput("busy_ign_reg1",      {16'd0, wrData[0]},  32'h0187);
    checkOutput("busy_ign_ack_count", ackCount,            32'd1);
    checkOutput("busy_ign_cur_div",   {25'd0, cur_div_o},  32'd13);
    checkOutput("busy_ign_idle",      {31'd0, busy_o},     32'd0);

    // Reset between the two DRP writes, then a clean request.
    autoDrdy = 1'b0;
    applyStimulus(13'd1000);
    while (wrCount == 0 && cycle < 100) stepCycle();
    checkOutput("midwr_first_den", wrCount, 32'd1);
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    checkResetValues("midwr");
    rst_n    = 1'b1;
    autoDrdy = 1'b1;
    stepCycle();
    runRequest(13'd2133, 200);
    checkOutput("post_rst_wr_count", wrCount,            32'd2);
    checkOutput("post_rst_reg1",     {16'd0, wrData[0]}, 32'h0042);
    checkOutput("post_rst_reg2",     {16'd0, wrData[1]}, 32'h0080);
    checkOutput("post_rst_ack_cyc",  ackCycle,           32'd23);
    checkOutput("post_rst_cur_div",  {25'd0, divAtAck},  32'd3);
    checkOutput("post_rst_err",      {31'd0, errAtAck},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
